reflet_int_to_float_arbiter: RTL and testbench

- Shares one combinational reflet_int_to_float converter between n_req requesters.
- Round-robin arbitration with valid/ready handshake on every requester port.
- Result goes into a one-deep registered output stage with the winner's id, and supports backpressure.
- Sits between integer producers (CPU core, DMA) and FPU consumers that need float operands.

---
 rtl/reflet_int_to_float_arbiter.sv | 105 ++++++++++
 tb/tb_reflet_int_to_float_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_int_to_float_arbiter.sv
// Round-robin arbiter sharing one combinational int-to-float converter between
// n_req requesters, with a one-deep registered output stage carrying the winner id.
module reflet_int_to_float_arbiter #(
  parameter int int_size   = 16,
  parameter int float_size = 32,
  parameter int n_req      = 4,
  localparam int id_w      = (n_req > 1) ? $clog2(n_req) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [n_req-1:0]            req_valid,
  output logic [n_req-1:0]            req_ready,
  input  logic [n_req*int_size-1:0]   req_int,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [float_size-1:0]       out_float,
  output logic [id_w-1:0]             out_id
);

  // Valid/ready: a transfer happens on a rising edge where both valid and ready
  // are high; ready never depends on the accept itself, and valid must hold until taken.

  localparam int exp_w = (float_size == 64) ? 11 : ((float_size == 16) ? 5 : 8);
  localparam int man_w = float_size - 1 - exp_w;
  localparam int bias  = (1 << (exp_w - 1)) - 1;

  logic [id_w-1:0]       ptr;
  logic [id_w-1:0]       win;
  logic                  found;
  logic                  can_accept;
  logic                  accept;
  logic [int_size-1:0]   sel_int;
  logic [float_size-1:0] conv;
  logic [id_w-1:0]       next_ptr;

  // Truncating conversion: the leading one is shifted out of the word, the
  // remaining fraction bits are left-aligned into the mantissa.
  function automatic logic [float_size-1:0] to_float(input logic [int_size-1:0] x);
    logic [int_size-1:0]       mag;
    logic [int_size-1:0]       norm;
    logic [int_size+man_w-1:0] wide;
    logic [exp_w-1:0]          e;
    logic [man_w-1:0]          m;
    int                        top;
    mag = x[int_size-1] ? -x : x;
    top = 0;
    for (int i = 0; i < int_size; i++) begin
      if (mag[i]) top = i;
    end
    norm = mag << (int_size - top);
    wide = {norm, {man_w{1'b0}}};
    m    = man_w'(wide >> int_size);
    e    = exp_w'(top + bias);
    if (x == '0) to_float = '0;
    else         to_float = {x[int_size-1], e, m};
  endfunction

  always_comb begin
    int              idx;
    logic [id_w-1:0] cand;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < n_req; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n_req) idx = idx - n_req;
      cand = id_w'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign can_accept = !out_valid || out_ready;
  assign accept     = found && can_accept && reset;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  assign sel_int  = req_int[int'(win)*int_size +: int_size];
  assign conv     = to_float(sel_int);
  assign next_ptr = (win == id_w'(n_req - 1)) ? '0 : win + id_w'(1);

  // An accept wins over a drain, so a simultaneous drain+accept keeps out_valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_float <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_float <= conv;
      out_id    <= win;
      ptr       <= next_ptr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reflet_int_to_float_arbiter.sv
// Bench for reflet_int_to_float_arbiter: directed conversion table, round-robin,
// backpressure and reset sequences, then a randomized scoreboard run.
module tb_reflet_int_to_float_arbiter;
  localparam int N    = 4;
  localparam int IW   = 16;
  localparam int FW   = 32;
  localparam int ID_W = 2;
  localparam int W    = ID_W + FW;

  logic             clk;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*IW-1:0]  req_int;
  logic             out_valid;
  logic             out_ready;
  logic [FW-1:0]    out_float;
  logic [ID_W-1:0]  out_id;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  reflet_int_to_float_arbiter #(.int_size(IW), .float_size(FW), .n_req(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_int(req_int), .out_valid(out_valid), .out_ready(out_ready),
    .out_float(out_float), .out_id(out_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_int   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [IW-1:0] x);
    req_valid[i]       = v;
    req_int[i*IW +: IW] = x;
  endtask

  // independent reference: exact int->double, repacked as single precision
  function automatic logic [FW-1:0] ref_conv(input logic [IW-1:0] x);
    int          xi;
    real         r;
    logic [63:0] d;
    if (x == '0) return '0;
    xi = int'($signed(x));
    r  = real'(xi);
    d  = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  typedef struct {
    int              id;
    logic [IW-1:0]   val;
    logic [FW-1:0]   flt;
  } vec_t;

  vec_t vecs[12];

  // random-run model state
  logic [N-1:0]  vld;
  logic [IW-1:0] ints[N];
  int            waits[N];
  logic          m_ov;
  int            m_ptr;

  initial begin
    vecs[0]  = '{0, 16'd1,      32'h3F800000};
    vecs[1]  = '{2, -16'sd2,    32'hC0000000};
    vecs[2]  = '{1, 16'd3,      32'h40400000};
    vecs[3]  = '{0, 16'd0,      32'h00000000};
    vecs[4]  = '{3, -16'sd1,    32'hBF800000};
    vecs[5]  = '{1, 16'd32767,  32'h46FFFE00};
    vecs[6]  = '{2, -16'sd32767, 32'hC6FFFE00};
    vecs[7]  = '{3, 16'd256,    32'h43800000};
    vecs[8]  = '{0, 16'd10,     32'h41200000};
    vecs[9]  = '{1, -16'sd100,  32'hC2C80000};
    vecs[10] = '{2, 16'd12345,  32'h4640E400};
    vecs[11] = '{3, 16'd16384,  32'h46800000};

    // reset state
    reset = 1'b0; req_valid = '0; req_int = '0; out_ready = 1'b1;
    #2;
    req_valid = '1;
    #1;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_float", 64'(out_float), 64'(0));
    check("rst_id",    64'(out_id),    64'(0));

    // conversion table, one requester at a time
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].val);
      #1;
      check($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(4'(1) << vecs[i].id));
      step();
      set_req(vecs[i].id, 1'b0, '0);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
      check($sformatf("vec%0d_float", i), 64'(out_float), 64'(vecs[i].flt));
      check($sformatf("vec%0d_id", i),    64'(out_id),    64'(vecs[i].id));
    end
    step();
    check("drain_valid", 64'(out_valid), 64'(0));

    // round robin with all requesters valid
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'(10 * (i + 1)));
    for (int k = 0; k < 5; k++) begin
      logic [FW-1:0] ef;
      case (k % 4)
        0: ef = 32'h41200000;
        1: ef = 32'h41A00000;
        2: ef = 32'h41F00000;
        default: ef = 32'h42200000;
      endcase
      #1;
      check($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(4'(1) << (k % 4)));
      step();
      check($sformatf("rr%0d_valid", k), 64'(out_valid), 64'(1));
      check($sformatf("rr%0d_id", k),    64'(out_id),    64'(k % 4));
      check($sformatf("rr%0d_float", k), 64'(out_float), 64'(ef));
    end

    // backpressure hold: last grant was 0, so ptr sits at 1
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("hold%0d_ready", k), 64'(req_ready), 64'(0));
      step();
      check($sformatf("hold%0d_valid", k), 64'(out_valid), 64'(1));
      check($sformatf("hold%0d_id", k),    64'(out_id),    64'(0));
      check($sformatf("hold%0d_float", k), 64'(out_float), 64'(32'h41200000));
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 64'(req_ready), 64'(4'b0010));
    step();
    check("release_id",    64'(out_id),    64'(1));
    check("release_float", 64'(out_float), 64'(32'h41A00000));

    // asynchronous reset mid-cycle with a result held
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_float", 64'(out_float), 64'(0));
    check("mid_rst_id",    64'(out_id),    64'(0));
    check("mid_rst_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("post_rst_ptr0", 64'(req_ready), 64'(4'b0001));
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, '0);
    set_req(3, 1'b1, 16'd1);
    #1;
    check("solo3_ready", 64'(req_ready), 64'(4'b1000));
    step();
    check("solo3_id",    64'(out_id),    64'(3));
    check("solo3_float", 64'(out_float), 64'(32'h3F800000));
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'd2);
    #1;
    check("wrap_ready", 64'(req_ready), 64'(4'b0001));
    step();
    check("wrap_id",    64'(out_id),    64'(0));

    // randomized run against the reference model and scoreboard
    do_reset();
    vld = '0; m_ov = 1'b0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin waits[i] = 0; ints[i] = '0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int           w;
      logic         can;
      logic [N-1:0] exp_rdy;
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 2) != 0) begin
          logic [IW-1:0] x;
          if ($urandom_range(0, 3) == 0) x = 16'(int'($urandom_range(0, 40)) - 20);
          else x = 16'($urandom_range(0, 65535));
          if (x == 16'h8000) x = 16'h7FFF;
          vld[i]  = 1'b1;
          ints[i] = x;
        end
        set_req(i, vld[i], ints[i]);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      can = !m_ov || out_ready;
      w   = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (w < 0 && vld[idx]) w = idx;
      end
      exp_rdy = (w >= 0 && can) ? (4'(1) << w) : '0;
      check("rand_ready", 64'(req_ready), 64'(exp_rdy));
      if (m_ov && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=%0h required=none", {out_id, out_float});
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("sb_data", 64'({out_id, out_float}), 64'(e));
        end
        m_ov = 1'b0;
      end
      if (exp_rdy != '0) begin
        exp_q.push_back({ID_W'(w), ref_conv(ints[w])});
        check("starve", 64'(waits[w] < N), 64'(1));
        waits[w] = 0;
        vld[w]   = 1'b0;
        for (int j = 0; j < N; j++) if (vld[j]) waits[j]++;
        m_ptr = (w + 1) % N;
        m_ov  = 1'b1;
      end
      step();
      check("rand_out_valid", 64'(out_valid), 64'(m_ov));
    end
    req_valid = '0;
    out_ready = 1'b1;
    #1;
    if (m_ov) begin
      logic [W-1:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("sb_final", 64'({out_id, out_float}), 64'(e));
    end
    step();
    check("sb_empty", 64'(exp_q.size()), 64'(0));

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
